// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and any matching stream transmitter.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Order of fields on the wire: word count (big-endian), payload words MSB first, XOR checksum.
  typedef enum logic [1:0] {
    FIELD_LEN_HI,
    FIELD_LEN_LO,
    FIELD_PAYLOAD,
    FIELD_CSUM
  } frame_field_t;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Shifts payload bytes into a big-endian word, tracks byte position and the running XOR checksum.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data_byte,
  output logic [31:0] word_next,
  output logic        last_byte,
  output logic [7:0]  csum
);

  logic [23:0] word;
  logic [1:0]  idx;

  // word_next is the completed word when the final byte of a word is being accepted.
  assign word_next = {word, data_byte};
  assign last_byte = (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (shift) begin
      word <= word_next[23:0];
      idx  <= idx + 2'd1;
      csum <= csum_step(csum, data_byte);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory as 32-bit words and verifies its checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t      state;
  logic [15:0] len;
  logic [15:0] len_word;
  logic        accept;
  logic        start_ok;
  logic        shift;
  logic [31:0] word_next;
  logic        last_byte;
  logic [7:0]  csum;

  // No byte is taken in the cycle a word is being written out.
  assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == CSUM) ||
                    ((state == DATA) && !wr_en);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign shift    = accept && (state == DATA);
  assign len_word = {len[15:8], in_byte};

  imem_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .shift     (shift),
    .data_byte (in_byte),
    .word_next (word_next),
    .last_byte (last_byte),
    .csum      (csum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            len          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_byte;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len <= len_word;
            if (32'(len_word) > 32'(DEPTH)) begin
              state <= ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (len_word == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // The move to CSUM happens after the write cycle so in_ready stays low during it.
          if (wr_en) begin
            if (words_loaded == len[ADDR_W:0]) state <= CSUM;
          end else if (shift && last_byte) begin
            wr_en        <= 1'b1;
            wr_addr      <= words_loaded[ADDR_W-1:0];
            wr_data      <= DATA_W'(word_next);
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
          end
        end
        CSUM: begin
          if (accept) begin
            busy <= 1'b0;
            if (in_byte == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
